fetch_ifid_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the hazard unit and decode stage.
- Owns the PC and next-PC selection: sequential, branch redirect, jump, and jump-register.
- Obeys the hazard unit's PCWrite / WriteIFID / flushifid controls, which are active-high hold/flush signals.
- Latches any redirect that arrives while the PC is held and applies it on the first unheld cycle.

---
 rtl/fetch_ifid_stage_if.sv | 32 +++
 rtl/fetch_ifid_stage.sv | 124 ++++++++++++
 tb/tb_fetch_ifid_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bus: hazard-unit controls, redirect requests, instruction memory and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_ifid_stage_if #(
    parameter int PC_W = 32
);
    logic            PCWrite;
    logic            WriteIFID;
    logic            flushifid;
    logic [2:0]      jump_sel;
    logic [25:0]     jump_index;
    logic [PC_W-1:0] jr_target;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc4;
    logic            ifid_valid;
    logic            redirect_pending;

    modport master (
        input  PCWrite, WriteIFID, flushifid, jump_sel, jump_index, jr_target,
               branch_taken, branch_target, imem_rdata,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid, redirect_pending
    );

    modport slave (
        output PCWrite, WriteIFID, flushifid, jump_sel, jump_index, jr_target,
               branch_taken, branch_target, imem_rdata,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, redirect_pending
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch (PC + next-PC select, held-redirect latch) and IF/ID pipeline register.
// Optional macro FETCH_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_ifid_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_ifid_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    typedef enum logic {RUN = 1'b0, HOLD_REDIRECT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pend_reg, pend_next;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     instr_reg;
    logic [PC_W-1:0] pc4_reg;
    logic            valid_reg;
    logic            redir_req;
    logic [PC_W-1:0] redir_raw, redir_target;

    assign pc_plus4 = pc_reg + PC_W'(4);

    // Redirect request, highest priority first; the J-type region comes from the instruction in ID.
    always_comb begin
        redir_req = 1'b1;
        redir_raw = bus.branch_target;
        if (bus.branch_taken)
            redir_raw = bus.branch_target;
        else if (bus.jump_sel == 3'd1)
            redir_raw = {pc4_reg[PC_W-1:28], bus.jump_index, 2'b00};
        else if (bus.jump_sel == 3'd2)
            redir_raw = bus.jr_target;
        else
            redir_req = 1'b0;
    end

    assign redir_target = redir_raw & ~PC_W'(3);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pend_next  = pend_reg;
        case (state_reg)
            RUN: begin
                if (!bus.PCWrite) begin
                    pc_next = redir_req ? redir_target : pc_plus4;
                end else if (redir_req) begin
                    pend_next  = redir_target;
                    state_next = HOLD_REDIRECT;
                end
            end
            HOLD_REDIRECT: begin
                if (redir_req)
                    pend_next = redir_target;
                if (!bus.PCWrite) begin
                    pc_next    = redir_req ? redir_target : pend_reg;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
        end
    end

    // Flush beats hold; a held PC with WriteIFID low simply reloads the same instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_reg <= '0;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (bus.flushifid) begin
            instr_reg <= '0;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (!bus.WriteIFID) begin
            instr_reg <= bus.imem_rdata;
            pc4_reg   <= pc_plus4;
            valid_reg <= 1'b1;
        end
    end

    assign bus.imem_addr        = pc_reg;
    assign bus.ifid_instr       = instr_reg;
    assign bus.ifid_pc4         = pc4_reg;
    assign bus.ifid_valid       = valid_reg;
    assign bus.redirect_pending = (state_reg == HOLD_REDIRECT);

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (bus.PCWrite && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (bus.flushifid && (flush_cnt_reg != 32'hFFFF_FFFF))
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios with literal expectations, then randomized
// stimulus compared every cycle against a behavioural model of the fetch/IF-ID rules.
module tb_fetch_ifid_stage;
    localparam int PC_W = 32;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   check_en = 0;

    fetch_ifid_stage_if #(.PC_W(PC_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] m_stall, m_flush;
`endif

    fetch_ifid_stage #(.PC_W(PC_W), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address-tagged instruction memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_ptgt, m_instr, m_pc4;
    bit          m_pend, m_valid;

    always @(posedge clk or posedge reset) begin
        bit          has;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
`ifdef FETCH_PERF_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
            has = 1;
            if (bus.branch_taken)       tgt = bus.branch_target;
            else if (bus.jump_sel == 1) tgt = {m_pc4[31:28], bus.jump_index, 2'b00};
            else if (bus.jump_sel == 2) tgt = bus.jr_target;
            else begin has = 0; tgt = 32'h0; end
            tgt[1:0] = 2'b00;
`ifdef FETCH_PERF_EN
            if (bus.PCWrite && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (bus.flushifid && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
            if (bus.flushifid) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!bus.WriteIFID) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
            end
            if (has && bus.PCWrite) begin
                m_pend = 1; m_ptgt = tgt;
            end else if (!bus.PCWrite) begin
                if (has)         m_pc = tgt;
                else if (m_pend) m_pc = m_ptgt;
                else             m_pc = m_pc + 32'd4;
                m_pend = 0;
            end
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            chk("m_imem_addr", bus.imem_addr, m_pc);
            chk("m_ifid_instr", bus.ifid_instr, m_instr);
            chk("m_ifid_pc4", bus.ifid_pc4, m_pc4);
            chk("m_ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
            chk("m_pending", {31'b0, bus.redirect_pending}, {31'b0, m_pend});
`ifdef FETCH_PERF_EN
            chk("m_stall_cnt", stall_cnt, m_stall);
            chk("m_flush_cnt", flush_cnt, m_flush);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit pcw, input bit wif, input bit fl, input logic [2:0] js,
                         input logic [25:0] ji, input logic [31:0] jr, input bit bt,
                         input logic [31:0] btg);
        bus.PCWrite = pcw; bus.WriteIFID = wif; bus.flushifid = fl;
        bus.jump_sel = js; bus.jump_index = ji; bus.jr_target = jr;
        bus.branch_taken = bt; bus.branch_target = btg;
    endtask

    task automatic free();
        drive(0, 0, 0, 3'd0, 26'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        free();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("rst_instr", bus.ifid_instr, 32'h0);
        chk("rst_pending", {31'b0, bus.redirect_pending}, 32'h0);
        check_en = 1;

        tick();
        $display("seq: addr=%h pc4=%h valid=%b", bus.imem_addr, bus.ifid_pc4, bus.ifid_valid);
        chk("seq1_addr", bus.imem_addr, 32'h4);
        chk("seq1_pc4", bus.ifid_pc4, 32'h4);
        chk("seq1_valid", {31'b0, bus.ifid_valid}, 32'h1);
        chk("seq1_instr", bus.ifid_instr, 32'hC3A5_0000);
        tick();
        chk("seq2_addr", bus.imem_addr, 32'h8);
        chk("seq2_pc4", bus.ifid_pc4, 32'h8);

        drive(1, 1, 0, 3'd0, 26'h0, 32'h0, 0, 32'h0);
        repeat (2) begin
            tick();
            $display("stall: addr=%h pc4=%h", bus.imem_addr, bus.ifid_pc4);
            chk("stall_addr", bus.imem_addr, 32'h8);
            chk("stall_pc4", bus.ifid_pc4, 32'h8);
        end
        free();
        tick();
        chk("resume1_addr", bus.imem_addr, 32'hC);
        chk("resume1_pc4", bus.ifid_pc4, 32'hC);
        tick();
        chk("resume2_addr", bus.imem_addr, 32'h10);

        drive(0, 0, 0, 3'd2, 26'h0, 32'h80, 1, 32'h40);
        tick();
        $display("branch+jr: addr=%h pc4=%h", bus.imem_addr, bus.ifid_pc4);
        chk("br_prio_addr", bus.imem_addr, 32'h40);
        chk("br_wrongpath_pc4", bus.ifid_pc4, 32'h14);

        drive(0, 0, 0, 3'd2, 26'h0, 32'h1000_0007, 0, 32'h0);
        tick();
        chk("jr_align_addr", bus.imem_addr, 32'h1000_0004);
        free();
        tick();
        chk("pre_j_pc4", bus.ifid_pc4, 32'h1000_0008);

        drive(1, 1, 0, 3'd1, 26'h10, 32'h0, 0, 32'h0);
        repeat (3) begin
            tick();
            $display("held jump: addr=%h pending=%b", bus.imem_addr, bus.redirect_pending);
            chk("hold_pending", {31'b0, bus.redirect_pending}, 32'h1);
            chk("hold_addr", bus.imem_addr, 32'h1000_0008);
        end
        free();
        tick();
        chk("jump_applied_addr", bus.imem_addr, 32'h1000_0040);
        chk("jump_pending_clr", {31'b0, bus.redirect_pending}, 32'h0);

        drive(0, 1, 1, 3'd0, 26'h0, 32'h0, 0, 32'h0);
        tick();
        $display("flush: valid=%b instr=%h addr=%h", bus.ifid_valid, bus.ifid_instr, bus.imem_addr);
        chk("flush_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("flush_instr", bus.ifid_instr, 32'h0);
        chk("flush_addr", bus.imem_addr, 32'h1000_0044);

        drive(0, 0, 0, 3'd2, 26'h0, 32'hFFFF_FFFF, 0, 32'h0);
        tick();
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        free();
        tick();
        $display("wrap: addr=%h pc4=%h", bus.imem_addr, bus.ifid_pc4);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4", bus.ifid_pc4, 32'h0);
        chk("wrap_valid", {31'b0, bus.ifid_valid}, 32'h1);

        drive(1, 0, 0, 3'd2, 26'h0, 32'h200, 0, 32'h0);
        tick();
        chk("prerst_pending", {31'b0, bus.redirect_pending}, 32'h1);
        #2 reset = 1'b1;
        #1;
        $display("async reset: addr=%h pending=%b", bus.imem_addr, bus.redirect_pending);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_pending", {31'b0, bus.redirect_pending}, 32'h0);
        chk("arst_valid", {31'b0, bus.ifid_valid}, 32'h0);
`ifdef FETCH_PERF_EN
        chk("arst_stall_cnt", stall_cnt, 32'h0);
        chk("arst_flush_cnt", flush_cnt, 32'h0);
`endif
        free();
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                  3'($urandom % 8), 26'($urandom), 32'($urandom),
                  ($urandom % 6) == 0, 32'($urandom));
            tick();
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
